// File: rtl/mem_stage_sram_controller_if.sv
// rtl/mem_stage_sram_controller_if.sv - pipeline request and 16-bit SRAM pin bundle
interface mem_stage_sram_controller_if #(
    parameter int SRAM_AW = 18
);
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport master (
        output wr_en, rd_en, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport slave (
        input  wr_en, rd_en, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/mem_stage_sram_controller.sv
// rtl/mem_stage_sram_controller.sv - 32-bit load/store split into two 16-bit SRAM accesses
module mem_stage_sram_controller #(
    parameter int ADDR_OFFSET = 1024,
    parameter int SRAM_AW     = 18,
    parameter int SRAM_WAIT   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    mem_stage_sram_controller_if.slave  bus
);
    localparam int              CW      = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(SRAM_WAIT);
    localparam logic [SRAM_AW:0] OFFSET = (SRAM_AW + 1)'(ADDR_OFFSET);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             op_wr;
    logic [SRAM_AW:0] addr_lat;
    logic [31:0]      wdata_lat;
    logic [31:0]      rdata_q;
    logic             req;
    logic             phase_end;
    logic [SRAM_AW:0] addr_off;
    logic             addr_unused;

    assign req       = bus.wr_en | bus.rd_en;
    assign phase_end = (cnt == CNT_MAX);
    // Only the bits that reach the SRAM word address are kept; the subtraction
    // still needs the low two bits so a borrow propagates correctly.
    assign addr_off    = addr_lat - OFFSET;
    assign addr_unused = ^{bus.address[31:SRAM_AW+1], addr_off[1:0]};
    assign bus.rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr     <= 1'b0;
            addr_lat  <= '0;
            wdata_lat <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && req) begin
                op_wr     <= bus.wr_en;
                addr_lat  <= bus.address[SRAM_AW:0];
                wdata_lat <= bus.wdata;
            end
            if (!op_wr && phase_end) begin
                if (state == LOW)
                    rdata_q[15:0] <= bus.sram_dq_in;
                else if (state == HIGH)
                    rdata_q[31:16] <= bus.sram_dq_in;
            end
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        case (state)
            IDLE: begin
                bus.ready = ~req;
                if (req) begin
                    state_n = LOW;
                    cnt_n   = '0;
                end
            end
            LOW, HIGH: begin
                if (phase_end) begin
                    cnt_n   = '0;
                    state_n = (state == LOW) ? HIGH : DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
                bus.sram_addr = {addr_off[SRAM_AW:2], state == HIGH};
                if (op_wr) begin
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_dq_out = (state == HIGH) ? wdata_lat[31:16] : wdata_lat[15:0];
                end else begin
                    bus.sram_oe_n = 1'b0;
                end
            end
            DONE: begin
                bus.ready = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
